uart_tx_sched: RTL

Round-robin scheduler that shares one UART transmit line among `NUM_REQ` byte requesters. It arbitrates pending bytes, latches the winner and the baud divisor, and frames the byte serially on `tx` with its own bit-period counter. It sits between the per-channel byte sources and the UART pad, replacing a free-running baud clock with a per-frame, clk-domain bit timer.

---
 rtl/uart_tx_sched.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmit line among NUM_REQ byte sources.
// Optional even-parity bit enabled by defining UART_TX_SCHED_PARITY_EN (default 8N1).
module uart_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          div,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [ID_W-1:0]      cur_id,
    output logic                 frame_done
);

`ifdef UART_TX_SCHED_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t         state_r, state_s;
    logic [15:0]    cnt_r, cnt_s;
    logic [2:0]     bit_idx_r, bit_idx_s;
    logic [7:0]     data_r, data_s;
    logic [15:0]    div_l_r, div_l_s;
    logic [ID_W-1:0] cur_id_r, cur_id_s;
    logic [ID_W-1:0] last_r, last_s;
    logic           tx_r, tx_s;
    logic           busy_r, busy_s;
    logic           frame_done_r, frame_done_s;

    logic           found_s;
    logic [ID_W-1:0] win_s;
    logic           cnt_last_s;
    logic [15:0]    div_clamp_s;

    // Round-robin search starting just above the last winner.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found_s && req_valid[(int'(last_r) + i) % NUM_REQ]) begin
                found_s = 1'b1;
                win_s   = ID_W'((int'(last_r) + i) % NUM_REQ);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Accept strobe is combinational so the transfer happens on the same edge.
    always_comb begin
        req_ready = '0;
        if (state_r == ST_IDLE && !rst && found_s) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    assign div_clamp_s = (div < 16'd2) ? 16'd2 : div;
    assign cnt_last_s  = (cnt_r == (div_l_r - 16'd1));

    // Frame sequencing, bit timer and next-cycle output values.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r + 16'd1;
        bit_idx_s    = bit_idx_r;
        data_s       = data_r;
        div_l_s      = div_l_r;
        cur_id_s     = cur_id_r;
        last_s       = last_r;
        tx_s         = 1'b1;
        frame_done_s = (state_r == ST_STOP) && (cnt_r == (div_l_r - 16'd2));
        case (state_r)
            ST_IDLE: begin
                cnt_s = 16'd0;
                if (found_s) begin
                    state_s  = ST_START;
                    data_s   = req_data[int'(win_s)*8 +: 8];
                    div_l_s  = div_clamp_s;
                    cur_id_s = win_s;
                    last_s   = win_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_last_s) begin
                    state_s   = ST_DATA;
                    cnt_s     = 16'd0;
                    bit_idx_s = 3'd0;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_last_s) begin
                    cnt_s     = 16'd0;
                    bit_idx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_STOP;
`endif
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef UART_TX_SCHED_PARITY_EN
            ST_PARITY: begin
                if (cnt_last_s) begin
                    state_s = ST_STOP;
                    cnt_s   = 16'd0;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_last_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = 16'd0;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 16'd0;
            end
        endcase

        // tx is registered, so it is computed from where the FSM is going.
        case (state_s)
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = data_s[bit_idx_s];
`ifdef UART_TX_SCHED_PARITY_EN
            ST_PARITY: tx_s = even_parity(data_r);
`endif
            default:  tx_s = 1'b1;
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 16'd0;
            bit_idx_r    <= 3'd0;
            data_r       <= 8'd0;
            div_l_r      <= 16'd2;
            cur_id_r     <= '0;
            last_r       <= ID_W'(NUM_REQ - 1);
            tx_r         <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            bit_idx_r    <= bit_idx_s;
            data_r       <= data_s;
            div_l_r      <= div_l_s;
            cur_id_r     <= cur_id_s;
            last_r       <= last_s;
            tx_r         <= tx_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign cur_id     = cur_id_r;
    assign frame_done = frame_done_r;

endmodule
